// File: rtl/enet_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : enet_tx_sched
// Purpose  : TX frame scheduler. It picks pause, zero-time pause or DMA data
//            frames for the MAC, inserts the inter-packet gap, and defers on
//            CRS in half duplex.
// Revision : 1.0 - initial release
// ============================================================================
module enet_tx_sched #(
  parameter int IPG_BYTES = 12
) (
  input  logic       tx_clk,
  input  logic       rst_n,
  input  logic       ether_en,
  input  logic       fden,
  input  logic       mii_select,
  input  logic       tx_stop,
  input  logic       pause_send,
  input  logic       pause_send_zero,
  input  logic       crs,
  input  logic       dma_frame_valid,
  output logic       dma_frame_grant,
  output logic       mac_start,
  output logic [1:0] mac_type,
  input  logic       mac_done,
  output logic       mac_abort,
  output logic       pause_mac_send,
  output logic       pause_mac_send_zero,
  output logic       tx_mac_stop
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEFER = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_IPG   = 3'd4
  } state_t;

  localparam logic [5:0] C_IPG_LAST   = 6'(IPG_BYTES - 1);
  localparam logic [1:0] C_TYPE_DATA  = 2'b00;
  localparam logic [1:0] C_TYPE_PAUSE = 2'b01;
  localparam logic [1:0] C_TYPE_ZERO  = 2'b10;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_mac_type, w_mac_type_nxt;
  logic [5:0] r_byte_cnt, w_byte_cnt_nxt;
  logic       r_sub, w_sub_nxt;
  logic       w_cand;
  logic [1:0] w_cand_type;
  logic       w_byte_end;

  // Zero-time pause outranks timed pause, which outranks data.
  // tx_stop only holds back data frames.
  always_comb begin
    w_cand      = pause_send_zero | pause_send | (dma_frame_valid & ~tx_stop);
    w_cand_type = C_TYPE_DATA;
    if (pause_send_zero) begin
      w_cand_type = C_TYPE_ZERO;
    end else if (pause_send) begin
      w_cand_type = C_TYPE_PAUSE;
    end
  end

  // In MII mode a byte time spans two cycles; r_sub marks the second half.
  assign w_byte_end = ~mii_select | r_sub;

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mac_type <= C_TYPE_DATA;
      r_byte_cnt <= 6'd0;
      r_sub      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mac_type <= w_mac_type_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_sub      <= w_sub_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_mac_type_nxt      = r_mac_type;
    w_byte_cnt_nxt      = r_byte_cnt;
    w_sub_nxt           = r_sub;
    mac_start           = 1'b0;
    dma_frame_grant     = 1'b0;
    mac_abort           = 1'b0;
    pause_mac_send      = 1'b0;
    pause_mac_send_zero = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cand) begin
          if (fden | ~crs) begin
            w_state_nxt    = ST_START;
            w_mac_type_nxt = w_cand_type;
          end else begin
            w_state_nxt = ST_DEFER;
          end
        end
      end
      ST_DEFER: begin
        if (!crs) w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        mac_start       = 1'b1;
        dma_frame_grant = (r_mac_type == C_TYPE_DATA);
        w_state_nxt     = ST_BUSY;
      end
      ST_BUSY: begin
        if (mac_done) begin
          w_state_nxt         = ST_IPG;
          w_byte_cnt_nxt      = 6'd0;
          w_sub_nxt           = 1'b0;
          pause_mac_send      = (r_mac_type == C_TYPE_PAUSE);
          pause_mac_send_zero = (r_mac_type == C_TYPE_ZERO);
        end
      end
      ST_IPG: begin
        if (w_byte_end) begin
          w_sub_nxt = 1'b0;
          if (r_byte_cnt == C_IPG_LAST) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 6'd1;
          end
        end else begin
          w_sub_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Disabling the port wins over everything, including a coincident mac_done.
    if (!ether_en) begin
      w_state_nxt         = ST_IDLE;
      w_byte_cnt_nxt      = 6'd0;
      w_sub_nxt           = 1'b0;
      pause_mac_send      = 1'b0;
      pause_mac_send_zero = 1'b0;
      mac_abort           = (r_state == ST_START) || (r_state == ST_BUSY);
    end
  end

  assign mac_type    = r_mac_type;
  // Gated by rst_n so that the level is 0 during reset even if tx_stop is held.
  assign tx_mac_stop = rst_n & tx_stop & ((r_state == ST_IDLE) || (r_state == ST_DEFER));

endmodule
`default_nettype wire

// File: tb/tb_enet_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_enet_tx_sched
// Purpose  : Directed scoreboard bench for enet_tx_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enet_tx_sched;
  localparam int IPG = 12;

  logic       tx_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ether_en, fden, mii_select, tx_stop, pause_send, pause_send_zero;
  logic       crs, dma_frame_valid, mac_done;
  logic       dma_frame_grant, mac_start, mac_abort, pause_mac_send;
  logic       pause_mac_send_zero, tx_mac_stop;
  logic [1:0] mac_type;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  // kind: 0 mac_start, 1 pause_mac_send, 2 pause_mac_send_zero, 3 mac_abort
  typedef struct {
    int         kind;
    logic [1:0] typ;
    logic       grant;
    int         at;
  } ev_t;
  ev_t q[$];

  enet_tx_sched #(.IPG_BYTES(IPG)) dut (
    .tx_clk              (tx_clk),
    .rst_n               (rst_n),
    .ether_en            (ether_en),
    .fden                (fden),
    .mii_select          (mii_select),
    .tx_stop             (tx_stop),
    .pause_send          (pause_send),
    .pause_send_zero     (pause_send_zero),
    .crs                 (crs),
    .dma_frame_valid     (dma_frame_valid),
    .dma_frame_grant     (dma_frame_grant),
    .mac_start           (mac_start),
    .mac_type            (mac_type),
    .mac_done            (mac_done),
    .mac_abort           (mac_abort),
    .pause_mac_send      (pause_mac_send),
    .pause_mac_send_zero (pause_mac_send_zero),
    .tx_mac_stop         (tx_mac_stop)
  );

  always #5 tx_clk = ~tx_clk;
  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge tx_clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic pulse_done(output int d);
    d        = cyc;
    mac_done = 1'b1;
    step(1);
    mac_done = 1'b0;
  endtask

  task automatic expect_ev(input int kind, input logic [1:0] typ, input logic grant, input int at);
    ev_t e;
    e.kind  = kind;
    e.typ   = typ;
    e.grant = grant;
    e.at    = at;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_mac_start"}, int'(mac_start), 0);
    chk({t, "_grant"}, int'(dma_frame_grant), 0);
    chk({t, "_mac_type"}, int'(mac_type), 0);
    chk({t, "_abort"}, int'(mac_abort), 0);
    chk({t, "_pause"}, int'(pause_mac_send), 0);
    chk({t, "_pause_zero"}, int'(pause_mac_send_zero), 0);
    chk({t, "_tx_mac_stop"}, int'(tx_mac_stop), 0);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d type=%0b grant=%0b at cycle %0d, required none",
               kind, mac_type, dma_frame_grant, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.typ != mac_type || e.grant != dma_frame_grant || e.at != cyc) begin
        n_err++;
        $display("FAIL event: got kind=%0d type=%0b grant=%0b cycle=%0d, required kind=%0d type=%0b grant=%0b cycle=%0d",
                 kind, mac_type, dma_frame_grant, cyc, e.kind, e.typ, e.grant, e.at);
      end
    end
  endtask

  always @(negedge tx_clk) begin
    if (rst_n) begin
      if (mac_start)           observe(0);
      if (pause_mac_send)      observe(1);
      if (pause_mac_send_zero) observe(2);
      if (mac_abort)           observe(3);
      if (dma_frame_grant && !mac_start) begin
        n_vec++;
        n_err++;
        $display("FAIL grant_without_start: got grant=1 at cycle %0d, required 0", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, d2, c;
    ether_en = 1'b1; fden = 1'b1; mii_select = 1'b0; tx_stop = 1'b1;
    pause_send = 1'b1; pause_send_zero = 1'b1; crs = 1'b0;
    dma_frame_valid = 1'b1; mac_done = 1'b0;
    step(2);
    chk_zero("reset");
    tx_stop = 1'b0; pause_send = 1'b0; pause_send_zero = 1'b0; dma_frame_valid = 1'b0;
    rst_n = 1'b1;
    step(2);

    // Data frame, RMII gap of IPG cycles before the next start.
    k = cyc; dma_frame_valid = 1'b1; expect_ev(0, 2'b00, 1'b1, k + 1);
    step(1); dma_frame_valid = 1'b0;
    wait_cyc(k + 3); pulse_done(d);
    dma_frame_valid = 1'b1; expect_ev(0, 2'b00, 1'b1, d + IPG + 2);
    wait_cyc(d + IPG + 2); dma_frame_valid = 1'b0;
    wait_cyc(d + IPG + 4); pulse_done(d);
    step(IPG + 4);

    // MII back-to-back gap, then mii_select drops mid-gap.
    mii_select = 1'b1;
    k = cyc; dma_frame_valid = 1'b1; expect_ev(0, 2'b00, 1'b1, k + 1);
    wait_cyc(k + 3); pulse_done(d); expect_ev(0, 2'b00, 1'b1, d + 2 * IPG + 2);
    wait_cyc(d + 2 * IPG + 4); pulse_done(d2); dma_frame_valid = 1'b0;
    wait_cyc(d2 + 5); mii_select = 1'b0; dma_frame_valid = 1'b1;
    expect_ev(0, 2'b00, 1'b1, d2 + 16);
    wait_cyc(d2 + 16); dma_frame_valid = 1'b0;
    wait_cyc(d2 + 18); pulse_done(d);
    step(IPG + 4);

    // Both pause levels plus data: order 10, 01, 00.
    k = cyc; pause_send = 1'b1; pause_send_zero = 1'b1; dma_frame_valid = 1'b1;
    expect_ev(0, 2'b10, 1'b0, k + 1);
    wait_cyc(k + 3); expect_ev(2, 2'b10, 1'b0, cyc); pulse_done(d); pause_send_zero = 1'b0;
    expect_ev(0, 2'b01, 1'b0, d + IPG + 2);
    wait_cyc(d + IPG + 4); expect_ev(1, 2'b01, 1'b0, cyc); pulse_done(d); pause_send = 1'b0;
    expect_ev(0, 2'b00, 1'b1, d + IPG + 2);
    wait_cyc(d + IPG + 2); dma_frame_valid = 1'b0;
    wait_cyc(d + IPG + 4); pulse_done(d);
    step(IPG + 4);

    // Half-duplex deferral; CRS during the gap does not stretch it.
    fden = 1'b0; crs = 1'b1; dma_frame_valid = 1'b1;
    step(20);
    chk("defer_no_start", int'(mac_start), 0);
    c = cyc; expect_ev(0, 2'b00, 1'b1, c + 2); crs = 1'b0;
    wait_cyc(c + 2); dma_frame_valid = 1'b0; crs = 1'b1;
    wait_cyc(c + 4); pulse_done(d);
    wait_cyc(d + IPG); crs = 1'b0; dma_frame_valid = 1'b1;
    expect_ev(0, 2'b00, 1'b1, d + IPG + 2);
    wait_cyc(d + IPG + 2); dma_frame_valid = 1'b0;
    wait_cyc(d + IPG + 4); pulse_done(d);
    fden = 1'b1;
    step(IPG + 4);

    // Graceful stop during BUSY, then a pause frame under stop.
    k = cyc; dma_frame_valid = 1'b1; expect_ev(0, 2'b00, 1'b1, k + 1);
    wait_cyc(k + 3); tx_stop = 1'b1; #2 chk("stop_busy", int'(tx_mac_stop), 0);
    wait_cyc(k + 4); pulse_done(d);
    wait_cyc(d + IPG); #2 chk("stop_ipg", int'(tx_mac_stop), 0);
    wait_cyc(d + IPG + 1); #2 chk("stop_idle", int'(tx_mac_stop), 1);
    pause_send = 1'b1; expect_ev(0, 2'b01, 1'b0, d + IPG + 2);
    wait_cyc(d + IPG + 2); #2 chk("stop_start", int'(tx_mac_stop), 0);
    wait_cyc(d + IPG + 4); expect_ev(1, 2'b01, 1'b0, cyc); pulse_done(d); pause_send = 1'b0;
    step(IPG + 6);
    chk("stop_hold", int'(tx_mac_stop), 1);
    dma_frame_valid = 1'b0; tx_stop = 1'b0;
    step(2);
    chk("stop_release", int'(tx_mac_stop), 0);

    // ether_en drop in the cycle after mac_start, with a coincident mac_done.
    k = cyc; pause_send = 1'b1; expect_ev(0, 2'b01, 1'b0, k + 1);
    wait_cyc(k + 2); ether_en = 1'b0; mac_done = 1'b1; expect_ev(3, 2'b01, 1'b0, k + 2);
    step(1); ether_en = 1'b1; mac_done = 1'b0; pause_send = 1'b0;
    step(3);

    // Asynchronous reset in the middle of a pause frame.
    k = cyc; pause_send = 1'b1; expect_ev(0, 2'b01, 1'b0, k + 1);
    wait_cyc(k + 3); tx_stop = 1'b1; mac_done = 1'b1; rst_n = 1'b0;
    #2 chk_zero("async_rst");
    pause_send = 1'b0; mac_done = 1'b0;
    step(2);
    tx_stop = 1'b0; rst_n = 1'b1;
    step(4);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
